// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the instruction/data cache memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_e     : which requester owns the memory port (OWN_IC, OWN_DC)
//   ADDR_W_DFLT : default byte-address width
//   LINE_W_DFLT : default cache-line width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int ADDR_W_DFLT = 20;
   localparam int LINE_W_DFLT = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_e;

endpackage

// File: rtl/arb_req_slot.sv
// -----------------------------------------------------------------------------
// arb_req_slot
// One pending-request slot. A set pulse captures the payload and raises
// pending; pending stays high through arbitration and service and drops only
// on clr (completion of this requester's transaction). A set pulse that
// arrives while pending is high is ignored, except on the clr edge itself,
// where the new request is captured so back-to-back requests are not lost.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   set     : request pulse
//   clr     : completion of the slot's transaction
//   payload : request payload sampled on an accepted set
//   pending : slot holds a request (waiting or in service)
//   held    : captured payload
// -----------------------------------------------------------------------------
module arb_req_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         set,
   input  logic         clr,
   input  logic [W-1:0] payload,
   output logic         pending,
   output logic [W-1:0] held
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         held    <= '0;
      end else if (set && (!pending || clr)) begin
         pending <= 1'b1;
         held    <= payload;
      end else if (clr) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates instruction-cache refills and data-cache reads/writebacks onto a
// single memory port. Each requester has one pending slot; the FSM picks an
// owner in IDLE, issues a one-cycle memory command in ISSUE and waits for the
// memory response in WAIT, which is returned on the shared response bus with
// a one-cycle ready pulse to the owner.
// Configuration macro:
//   MEM_ARB_RR_EN : when both slots are pending, grant the requester not
//                   granted last (last-grant resets to the instruction cache).
//                   Undefined: fixed priority, data cache over instr. cache.
// Ports:
//   clk_i, rsn_i                       : clock, async active-high reset
//   ic_rqst_i, ic_addr_i               : instruction-cache refill request
//   dc_rqst_i, dc_we_i, dc_addr_i,
//   dc_wdata_i                         : data-cache read / writeback request
//   ic_ready_o, dc_ready_o             : per-requester response pulse
//   rsp_data_o, rsp_addr_o             : shared response line and address
//   mem_rqst_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                        : memory command (held until next issue)
//   mem_ready_i, mem_data_i, mem_addr_i: memory response
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int LINE_W = LINE_W_DFLT
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              ic_rqst_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic              dc_rqst_i,
   input  logic              dc_we_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [LINE_W-1:0] dc_wdata_i,
   output logic              ic_ready_o,
   output logic              dc_ready_o,
   output logic [LINE_W-1:0] rsp_data_o,
   output logic [ADDR_W-1:0] rsp_addr_o,
   output logic              mem_rqst_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic [ADDR_W-1:0] mem_addr_i
);

   localparam int DC_W = 1 + ADDR_W + LINE_W;

   arb_state_e        state, state_nxt;
   owner_e            owner;
   owner_e            sel;
   logic              grant_en;
   logic              done;

   logic              ic_pend, dc_pend;
   logic              ic_clr, dc_clr;
   logic [ADDR_W-1:0] ic_addr_h;
   logic              dc_we_h;
   logic [ADDR_W-1:0] dc_addr_h;
   logic [LINE_W-1:0] dc_wdata_h;

   assign ic_clr = done && (owner == OWN_IC);
   assign dc_clr = done && (owner == OWN_DC);

   arb_req_slot #(.W(ADDR_W)) u_ic_slot (
      .clk     (clk_i),
      .rst     (rsn_i),
      .set     (ic_rqst_i),
      .clr     (ic_clr),
      .payload (ic_addr_i),
      .pending (ic_pend),
      .held    (ic_addr_h)
   );

   arb_req_slot #(.W(DC_W)) u_dc_slot (
      .clk     (clk_i),
      .rst     (rsn_i),
      .set     (dc_rqst_i),
      .clr     (dc_clr),
      .payload ({dc_we_i, dc_addr_i, dc_wdata_i}),
      .pending (dc_pend),
      .held    ({dc_we_h, dc_addr_h, dc_wdata_h})
   );

   // Owner selection; only consulted in IDLE, where neither slot is in service.
`ifdef MEM_ARB_RR_EN
   owner_e last_grant;

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i)         last_grant <= OWN_IC;
      else if (grant_en) last_grant <= sel;
   end

   always_comb begin
      if (ic_pend && dc_pend) sel = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
      else                    sel = dc_pend ? OWN_DC : OWN_IC;
   end
`else
   always_comb begin
      sel = dc_pend ? OWN_DC : OWN_IC;
   end
`endif

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (ic_pend || dc_pend) begin
               grant_en  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            // mem_ready_i is only meaningful here; elsewhere it is ignored.
            if (mem_ready_i) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs: the command is loaded on the IDLE->ISSUE edge and
   // held until the next grant; mem_rqst_o is therefore high exactly in ISSUE.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         owner       <= OWN_IC;
         mem_rqst_o  <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         ic_ready_o  <= 1'b0;
         dc_ready_o  <= 1'b0;
         rsp_data_o  <= '0;
         rsp_addr_o  <= '0;
      end else begin
         mem_rqst_o <= grant_en;
         ic_ready_o <= ic_clr;
         dc_ready_o <= dc_clr;
         if (grant_en) begin
            owner <= sel;
            if (sel == OWN_DC) begin
               mem_we_o    <= dc_we_h;
               mem_addr_o  <= dc_addr_h;
               mem_wdata_o <= dc_wdata_h;
            end else begin
               mem_we_o    <= 1'b0;
               mem_addr_o  <= ic_addr_h;
               mem_wdata_o <= '0;
            end
         end
         if (done) begin
            rsp_data_o <= mem_data_i;
            rsp_addr_o <= mem_addr_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter (default parameters).
// Inputs are driven 1 ns after the rising edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 20;
   localparam int LW = 128;

   logic          clk_i = 1'b0;
   logic          rsn_i = 1'b1;
   logic          ic_rqst_i = 1'b0;
   logic [AW-1:0] ic_addr_i = '0;
   logic          dc_rqst_i = 1'b0;
   logic          dc_we_i = 1'b0;
   logic [AW-1:0] dc_addr_i = '0;
   logic [LW-1:0] dc_wdata_i = '0;
   logic          ic_ready_o, dc_ready_o;
   logic [LW-1:0] rsp_data_o;
   logic [AW-1:0] rsp_addr_o;
   logic          mem_rqst_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_wdata_o;
   logic          mem_ready_i = 1'b0;
   logic [LW-1:0] mem_data_i = '0;
   logic [AW-1:0] mem_addr_i = '0;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter dut (
      .clk_i       (clk_i),
      .rsn_i       (rsn_i),
      .ic_rqst_i   (ic_rqst_i),
      .ic_addr_i   (ic_addr_i),
      .dc_rqst_i   (dc_rqst_i),
      .dc_we_i     (dc_we_i),
      .dc_addr_i   (dc_addr_i),
      .dc_wdata_i  (dc_wdata_i),
      .ic_ready_o  (ic_ready_o),
      .dc_ready_o  (dc_ready_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_addr_o  (rsp_addr_o),
      .mem_rqst_o  (mem_rqst_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ready_i (mem_ready_i),
      .mem_data_i  (mem_data_i),
      .mem_addr_i  (mem_addr_i)
   );

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_ic(input logic [AW-1:0] addr);
      ic_rqst_i = 1'b1;
      ic_addr_i = addr;
      tick();
      ic_rqst_i = 1'b0;
   endtask

   task automatic pulse_dc(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
      dc_rqst_i  = 1'b1;
      dc_we_i    = we;
      dc_addr_i  = addr;
      dc_wdata_i = wdata;
      tick();
      dc_rqst_i  = 1'b0;
   endtask

   // Waits (bounded) for mem_rqst_o, then checks the command fields.
   task automatic expect_issue(input string tag, input logic we, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wdata);
      int n = 0;
      while (!mem_rqst_o && n < 8) begin
         tick();
         n++;
      end
      check({tag, "_rqst"}, LW'(mem_rqst_o), LW'(1));
      check({tag, "_we"}, LW'(mem_we_o), LW'(we));
      check({tag, "_addr"}, LW'(mem_addr_o), LW'(addr));
      check({tag, "_wdata"}, mem_wdata_o, wdata);
   endtask

   // Waits the given cycles, then presents one response beat.
   task automatic respond(input int wait_cycles, input logic [LW-1:0] data, input logic [AW-1:0] addr);
      repeat (wait_cycles) tick();
      mem_ready_i = 1'b1;
      mem_data_i  = data;
      mem_addr_i  = addr;
      tick();
      mem_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [LW-1:0] a5_line;
      logic [LW-1:0] line1;
      logic [AW-1:0] first_addr, second_addr;
      int            rq_cnt;

      a5_line = {16{8'hA5}};
      line1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_rqst", LW'(mem_rqst_o), '0);
      check("rst_ready", LW'({ic_ready_o, dc_ready_o}), '0);
      check("rst_addr", LW'(mem_addr_o), '0);
      rsn_i = 1'b0;
      tick();

      // Single instruction-cache refill with exact latency
      pulse_ic(20'h00040);
      check("ic1_lat_early", LW'(mem_rqst_o), '0);
      tick();
      check("ic1_lat_rqst", LW'(mem_rqst_o), LW'(1));
      check("ic1_addr", LW'(mem_addr_o), LW'(20'h00040));
      check("ic1_we", LW'(mem_we_o), '0);
      respond(2, line1, 20'h00040);
      check("ic1_ic_ready", LW'(ic_ready_o), LW'(1));
      check("ic1_dc_ready", LW'(dc_ready_o), '0);
      check("ic1_rsp_data", rsp_data_o, line1);
      check("ic1_rsp_addr", LW'(rsp_addr_o), LW'(20'h00040));
      tick();
      check("ic1_ready_pulse", LW'(ic_ready_o), '0);
      check("ic1_cmd_hold", LW'(mem_addr_o), LW'(20'h00040));

      // Data-cache writeback
      pulse_dc(1'b1, 20'h00100, a5_line);
      expect_issue("wb", 1'b1, 20'h00100, a5_line);
      respond(1, '0, 20'h00100);
      check("wb_dc_ready", LW'(dc_ready_o), LW'(1));
      check("wb_ic_ready", LW'(ic_ready_o), '0);
      tick();
      check("wb_ready_pulse", LW'(dc_ready_o), '0);

      // Simultaneous requests; last grant was dc
`ifdef MEM_ARB_RR_EN
      first_addr  = 20'h00111;
      second_addr = 20'h00222;
`else
      first_addr  = 20'h00222;
      second_addr = 20'h00111;
`endif
      ic_addr_i  = 20'h00111;
      dc_addr_i  = 20'h00222;
      dc_we_i    = 1'b0;
      dc_wdata_i = '0;
      ic_rqst_i  = 1'b1;
      dc_rqst_i  = 1'b1;
      tick();
      ic_rqst_i  = 1'b0;
      dc_rqst_i  = 1'b0;
      expect_issue("both_first", 1'b0, first_addr, '0);
      // A response during ISSUE must be ignored
      mem_ready_i = 1'b1;
      mem_addr_i  = 20'hFFFFF;
      tick();
      mem_ready_i = 1'b0;
      tick();
      check("issue_rdy_ign", LW'({ic_ready_o, dc_ready_o}), '0);
      respond(0, line1, first_addr);
      check("both_first_ready", LW'({ic_ready_o, dc_ready_o}),
            (first_addr == 20'h00222) ? LW'(2'b01) : LW'(2'b10));
      expect_issue("both_second", 1'b0, second_addr, '0);
      respond(1, ~line1, second_addr);
      check("both_second_ready", LW'({ic_ready_o, dc_ready_o}),
            (second_addr == 20'h00222) ? LW'(2'b01) : LW'(2'b10));
      check("both_second_data", rsp_data_o, ~line1);

      // Second ic request while ic is in service is dropped
      pulse_ic(20'h00300);
      expect_issue("dup", 1'b0, 20'h00300, '0);
      tick();
      pulse_ic(20'h00310);
      respond(0, line1, 20'h00300);
      check("dup_ready", LW'(ic_ready_o), LW'(1));
      rq_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (mem_rqst_o) rq_cnt++;
      end
      check("dup_no_reissue", LW'(rq_cnt), '0);

      // Request on the same edge as its own completion is latched
      pulse_ic(20'h00400);
      expect_issue("b2b_a", 1'b0, 20'h00400, '0);
      tick();
      mem_ready_i = 1'b1;
      mem_addr_i  = 20'h00400;
      ic_rqst_i   = 1'b1;
      ic_addr_i   = 20'h00410;
      tick();
      mem_ready_i = 1'b0;
      ic_rqst_i   = 1'b0;
      check("b2b_a_ready", LW'(ic_ready_o), LW'(1));
      expect_issue("b2b_b", 1'b0, 20'h00410, '0);
      respond(1, line1, 20'h00410);
      check("b2b_b_ready", LW'(ic_ready_o), LW'(1));

      // Reset during WAIT, then a stale response
      pulse_dc(1'b1, 20'h00500, a5_line);
      expect_issue("rst_wait", 1'b1, 20'h00500, a5_line);
      tick();
      #3;
      rsn_i = 1'b1;
      #1;
      check("rstw_rqst_we", LW'({mem_rqst_o, mem_we_o}), '0);
      check("rstw_addr", LW'(mem_addr_o), '0);
      check("rstw_wdata", mem_wdata_o, '0);
      check("rstw_rsp", rsp_data_o | LW'(rsp_addr_o), '0);
      tick();
      rsn_i = 1'b0;
      tick();
      respond(0, line1, 20'h00500);
      check("stale_ready", LW'({ic_ready_o, dc_ready_o}), '0);
      check("stale_rsp_addr", LW'(rsp_addr_o), '0);
      rq_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_rqst_o || ic_ready_o || dc_ready_o) rq_cnt++;
      end
      check("stale_quiet", LW'(rq_cnt), '0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
